// File: rtl/wb32to16_bridge.sv
// 32-bit pipelined Wishbone slave to two 16-bit Wishbone master beats (low halfword first).
// Optional build macro WB32TO16_SEL_SKIP_EN: write beats with an all-zero sel pair are not issued.
module wb32to16_bridge #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_wb_cyc_i,
  input  logic          s_wb_stb_i,
  input  logic          s_wb_we_i,
  input  logic [AW-2:0] s_wb_adr_i,
  input  logic [31:0]   s_wb_dat_i,
  input  logic [3:0]    s_wb_sel_i,
  output logic [31:0]   s_wb_dat_o,
  output logic          s_wb_ack_o,
  output logic          s_wb_stall_o,
  output logic          m_wb_cyc_o,
  output logic          m_wb_stb_o,
  output logic          m_wb_we_o,
  output logic [AW-1:0] m_wb_adr_o,
  output logic [15:0]   m_wb_dat_o,
  output logic [1:0]    m_wb_sel_o,
  input  logic [15:0]   m_wb_dat_i,
  input  logic          m_wb_ack_i,
  input  logic          m_wb_stall_i
);
  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [AW-2:0] adr_q, adr_n;
  logic [31:0]   dat_q, dat_n;
  logic [3:0]    sel_q, sel_n;
  logic          we_q, we_n, abort_q, abort_n;
  logic [1:0]    cnt_q, cnt_n, need_q, need_n;
  logic [15:0]   rlo_q, rlo_n, rhi_q, rhi_n;
  logic          accept, busy, ack_in;

  assign accept = s_wb_cyc_i & s_wb_stb_i & ~s_wb_stall_o;
  assign busy   = (state == LO) | (state == HI) | (state == WAIT);
  assign ack_in = busy & m_wb_ack_i;

  always_comb begin
    state_n = state;
    adr_n   = adr_q;
    dat_n   = dat_q;
    sel_n   = sel_q;
    we_n    = we_q;
    need_n  = need_q;
    cnt_n   = cnt_q + {1'b0, ack_in};
    // an upstream cycle drop anywhere after accept only suppresses the final ack
    abort_n = abort_q | ((state != IDLE) & ~s_wb_cyc_i);
    rlo_n   = (ack_in && cnt_q == 2'd0) ? m_wb_dat_i : rlo_q;
    rhi_n   = (ack_in && cnt_q == 2'd1) ? m_wb_dat_i : rhi_q;
    case (state)
      IDLE: if (accept) begin
        adr_n   = s_wb_adr_i;
        dat_n   = s_wb_dat_i;
        sel_n   = s_wb_sel_i;
        we_n    = s_wb_we_i;
        cnt_n   = 2'd0;
        abort_n = 1'b0;
        need_n  = 2'd2;
        state_n = LO;
`ifdef WB32TO16_SEL_SKIP_EN
        if (s_wb_we_i) begin
          need_n = {1'b0, |s_wb_sel_i[1:0]} + {1'b0, |s_wb_sel_i[3:2]};
          if (s_wb_sel_i == 4'b0000)       state_n = RESP;
          else if (s_wb_sel_i[1:0] == 2'b00) state_n = HI;
        end
`endif
      end
      LO: if (!m_wb_stall_i) begin
        state_n = HI;
`ifdef WB32TO16_SEL_SKIP_EN
        if (we_q && sel_q[3:2] == 2'b00) state_n = (cnt_n == need_q) ? RESP : WAIT;
`endif
      end
      // zero-latency downstream can complete the count while the HI beat issues
      HI:   if (!m_wb_stall_i) state_n = (cnt_n == need_q) ? RESP : WAIT;
      WAIT: if (cnt_n == need_q) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      need_q       <= '0;
      rlo_q        <= '0;
      rhi_q        <= '0;
      s_wb_dat_o   <= '0;
      s_wb_ack_o   <= 1'b0;
      s_wb_stall_o <= 1'b0;
      m_wb_cyc_o   <= 1'b0;
      m_wb_stb_o   <= 1'b0;
      m_wb_we_o    <= 1'b0;
      m_wb_adr_o   <= '0;
      m_wb_dat_o   <= '0;
      m_wb_sel_o   <= '0;
    end else begin
      state        <= state_n;
      adr_q        <= adr_n;
      dat_q        <= dat_n;
      sel_q        <= sel_n;
      we_q         <= we_n;
      abort_q      <= abort_n;
      cnt_q        <= cnt_n;
      need_q       <= need_n;
      rlo_q        <= rlo_n;
      rhi_q        <= rhi_n;
      // outputs are registered from the next state so they line up with it
      m_wb_cyc_o   <= (state_n == LO) | (state_n == HI) | (state_n == WAIT);
      m_wb_stb_o   <= (state_n == LO) | (state_n == HI);
      m_wb_we_o    <= we_n & ((state_n == LO) | (state_n == HI) | (state_n == WAIT));
      m_wb_adr_o   <= {adr_n, state_n == HI};
      m_wb_dat_o   <= (state_n == HI) ? dat_n[31:16] : dat_n[15:0];
      m_wb_sel_o   <= (state_n == HI) ? sel_n[3:2] : sel_n[1:0];
      s_wb_stall_o <= (state_n != IDLE);
      s_wb_ack_o   <= (state_n == RESP) & ~abort_n;
      if (state_n == RESP && !abort_n && !we_n) s_wb_dat_o <= {rhi_n, rlo_n};
    end
  end
endmodule

// File: doc/wb32to16_bridge.md
Name: wb32to16_bridge

Overview:
- Upstream neighbour of wbsdram: converts 32-bit pipelined Wishbone slave accesses into two 16-bit pipelined Wishbone master beats on the SDRAM controller bus.
- Allows a 32-bit CPU or DMA master to use the 16-bit SDRAM.
- One 32-bit transaction in flight at a time; low halfword first (little-endian).

Parameters:
AW, 24, downstream halfword address width (matches wbsdram); upstream word address is AW-1 bits

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
s_wb_cyc_i  input  1  upstream cycle
s_wb_stb_i  input  1  upstream strobe
s_wb_we_i  input  1  upstream write enable
s_wb_adr_i  input  AW-1  upstream 32-bit word address
s_wb_dat_i  input  32  upstream write data
s_wb_sel_i  input  4  upstream byte selects
s_wb_dat_o  output  32  upstream read data
s_wb_ack_o  output  1  upstream acknowledge
s_wb_stall_o  output  1  upstream stall
m_wb_cyc_o  output  1  to wbsdram wb_cyc_i
m_wb_stb_o  output  1  to wbsdram wb_stb_i
m_wb_we_o  output  1  to wbsdram wb_we_i
m_wb_adr_o  output  AW  to wbsdram wb_adr_i
m_wb_dat_o  output  16  to wbsdram wb_dat_i
m_wb_sel_o  output  2  to wbsdram wb_sel_i
m_wb_dat_i  input  16  from wbsdram wb_dat_o
m_wb_ack_i  input  1  from wbsdram wb_ack_o
m_wb_stall_i  input  1  from wbsdram wb_stall_o

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; ack counter 0; latched address, data, sel and we cleared. Reset mid-transaction abandons it, and m_wb_cyc_o drops immediately.
- Accept condition: s_wb_cyc_i & s_wb_stb_i & !s_wb_stall_o. s_wb_stall_o=0 only in IDLE.
- FSM: IDLE -> LO -> HI -> WAIT -> RESP -> IDLE.
  - IDLE: on accept, latch adr, dat, sel, we; go to LO.
  - LO:
    - m_wb_cyc_o=1, m_wb_stb_o=1.
    - m_wb_adr_o={adr,1'b0}, m_wb_dat_o=dat[15:0], m_wb_sel_o=sel[1:0].
    - Advance to HI when !m_wb_stall_i; otherwise hold all outputs stable.
  - HI:
    - m_wb_adr_o={adr,1'b1}, m_wb_dat_o=dat[31:16], m_wb_sel_o=sel[3:2].
    - Advance to WAIT when !m_wb_stall_i.
  - WAIT: m_wb_stb_o=0, m_wb_cyc_o=1. When the second ack is counted, go to RESP.
  - RESP:
    - m_wb_cyc_o=0.
    - s_wb_ack_o=1 for exactly one cycle with s_wb_dat_o valid; return to IDLE.
- m_wb_we_o equals the latched we throughout LO..WAIT.
- Ack counter (2 bits):
  - Increments on m_wb_ack_i in LO, HI or WAIT.
  - Acks may arrive in LO or HI, including the same cycle the HI beat issues.
  - The count reaching 2 in HI (possible only with zero-latency downstream) makes the next state RESP, skipping WAIT.
- Read data: first ack captures m_wb_dat_i into s_wb_dat_o[15:0]; second ack captures [31:16]. s_wb_dat_o holds its value until the next read response. Write responses leave s_wb_dat_o unchanged.
- m_wb_ack_i in IDLE or RESP is ignored (spurious).
- Upstream abort: s_wb_cyc_i dropping after accept does not stop the downstream sequence. Both beats complete, but s_wb_ack_o is suppressed in RESP.
- Latency with no downstream stall and ack 1 cycle after stb: accept at T0, LO at T1, HI at T2, acks at T2 and T3, RESP (s_wb_ack_o) at T4.

Optional Feature:
- Macro: WB32TO16_SEL_SKIP_EN.
- Defined:
  - Write beats whose sel pair is 2'b00 are not issued; the FSM skips that beat state and the expected ack count drops by 1.
  - A write with s_wb_sel_i=4'b0000 goes IDLE -> RESP directly with no downstream cycle.
  - Reads always issue both beats.
- Undefined: both beats are always issued regardless of sel.

Test Plan:
- Write 0xA5A55A5A, sel 4'hF, word adr 0x000010 -> downstream writes 0x5A5A @0x000020 sel 2'b11, then 0xA5A5 @0x000021 sel 2'b11; one s_wb_ack_o.
- Read word adr 0x000010 after the write above -> s_wb_dat_o=0xA5A55A5A with a single-cycle ack; two downstream reads at 0x000020 and 0x000021.
- Write sel 4'b1100, data 0x12345678 -> low beat sel 2'b00 and high beat data 0x1234 sel 2'b11. With SEL_SKIP_EN, only the 0x000021 beat is issued.
- m_wb_stall_i held high 5 cycles during LO -> m_wb_adr_o, m_wb_dat_o and m_wb_sel_o stable for all 5 cycles; s_wb_stall_o=1 throughout; completion is correct afterwards.
- s_wb_cyc_i dropped in WAIT -> both downstream acks consumed, no s_wb_ack_o, IDLE afterwards; the next read returns correct data.
- rst_n asserted in HI -> m_wb_cyc_o and m_wb_stb_o are 0 before the next clk edge; after release a fresh write/read pair completes correctly.
